// File: rtl/audio_pcm_arbiter.sv
// Round-robin arbiter sharing the stereo PCM FIFO write port between NUM_SRC producers.
// Optional HOLD-cycle stall counter is enabled by defining AUDIO_ARB_STATS_EN.
module audio_pcm_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int MIN_GAP = 2
) (
    input  logic                  clk_pcm,
    input  logic                  aclr_n,
    input  logic [NUM_SRC-1:0]    src_enable,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [16*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]    src_ready,
    output logic [15:0]           stereo_pcm,
    output logic                  stereo_pcm_rdy,
    input  logic                  fifo_full,
    output logic                  busy
`ifdef AUDIO_ARB_STATS_EN
    ,
    output logic [15:0]           stall_count,
    input  logic                  stats_clr
`endif
);

    localparam int IDX_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [15:0]        win_data;
    logic [3:0]         gap_cnt;
    logic [NUM_SRC-1:0] eligible;
    logic               grant;
    int                 cand;

    assign eligible = src_valid & src_enable;
    assign busy     = (state != IDLE);

    // Search upward from the last winner, wrapping, so the previous winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_SRC;
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
                win_data  = src_data[cand*16 +: 16];
            end
        end
    end

    // Grant is qualified by aclr_n so src_ready stays low while reset is held.
    always_comb begin
        state_nxt      = state;
        grant          = 1'b0;
        stereo_pcm_rdy = 1'b0;
        src_ready      = '0;
        case (state)
            IDLE: begin
                if (aclr_n && win_found && !fifo_full && (gap_cnt == 4'd0)) begin
                    grant              = 1'b1;
                    src_ready[win_idx] = 1'b1;
                    state_nxt          = WRITE;
                end
            end
            WRITE, HOLD: begin
                if (!fifo_full) begin
                    stereo_pcm_rdy = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    state_nxt      = HOLD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_pcm or negedge aclr_n) begin
        if (!aclr_n) begin
            state      <= IDLE;
            rr_ptr     <= IDX_W'(NUM_SRC - 1);
            gap_cnt    <= 4'd0;
            stereo_pcm <= 16'd0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                rr_ptr     <= win_idx;
                stereo_pcm <= win_data;
            end
            if (stereo_pcm_rdy) begin
                gap_cnt <= 4'(MIN_GAP - 1);
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

`ifdef AUDIO_ARB_STATS_EN
    // Clear takes priority over a simultaneous HOLD increment; the count saturates.
    always_ff @(posedge clk_pcm or negedge aclr_n) begin
        if (!aclr_n) begin
            stall_count <= 16'd0;
        end else if (stats_clr) begin
            stall_count <= 16'd0;
        end else if ((state == HOLD) && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
